// File: rtl/avgmax_unit_if.sv
// SRAM read port bundle between avgmax_unit and the result SRAM.
// master drives cs_n/we_n/addr and receives rdata; slave is the SRAM side.
interface avgmax_unit_if #(
  parameter int ADDR_W = 8
);
  logic              cs_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       rdata;

  modport master (
    output cs_n, we_n, addr,
    input  rdata
  );

  modport slave (
    input  cs_n, we_n, addr,
    output rdata
  );
endinterface

// File: rtl/avgmax_unit.sv
// Reads NUM_WORDS results from SRAM, tracks max and sum, and serialises
// {max, avg} MSB-first on P_out. Ports: clk/rst, avgmax_en start, P_s
// shift enable, sram (master), P_out/p_valid frame, busy, avgmax_done,
// max_val/avg_val results.
module avgmax_unit #(
  parameter int ADDR_W    = 8,
  parameter int NUM_WORDS = 32,
  parameter int LOG2_N    = 5,
  parameter int DATA_W    = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              avgmax_en,
  input  logic              P_s,
  avgmax_unit_if.master     sram,
  output logic              P_out,
  output logic              p_valid,
  output logic              busy,
  output logic              avgmax_done,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] avg_val
);

  localparam int SUM_W   = DATA_W + LOG2_N;
  localparam int FRAME_W = 2 * DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_CALC,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                cs_n_q, cs_n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rvalid_q, rvalid_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [DATA_W-1:0]   max_val_q, max_val_d;
  logic [DATA_W-1:0]   avg_val_q, avg_val_d;
  logic [FRAME_W-1:0]  sh_q, sh_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                p_out_q, p_out_d;
  logic                p_valid_q, p_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   word;
  logic                unused_rdata_hi;

  assign word            = sram.rdata[DATA_W-1:0];
  assign unused_rdata_hi = ^sram.rdata[31:DATA_W];

  always_comb begin
    state_d   = state_q;
    cs_n_d    = cs_n_q;
    addr_d    = addr_q;
    sum_d     = sum_q;
    max_d     = max_q;
    max_val_d = max_val_q;
    avg_val_d = avg_val_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    p_out_d   = p_out_q;
    p_valid_d = 1'b0;
    done_d    = 1'b0;
    rvalid_d  = (state_q == S_READ);

    // Data returns one cycle after its address; the last word lands in DRAIN.
    if (rvalid_q) begin
      sum_d = sum_q + SUM_W'(word);
      if (word > max_q) max_d = word;
    end

    unique case (state_q)
      S_IDLE: begin
        if (avgmax_en) begin
          state_d = S_READ;
          sum_d   = '0;
          max_d   = '0;
          addr_d  = '0;
          cs_n_d  = 1'b0;
        end
      end
      S_READ: begin
        if (addr_q == ADDR_W'(NUM_WORDS - 1)) begin
          state_d = S_DRAIN;
          cs_n_d  = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_CALC;
      end
      S_CALC: begin
        avg_val_d = sum_q[LOG2_N +: DATA_W];
        max_val_d = max_q;
        sh_d      = {max_q, sum_q[LOG2_N +: DATA_W]};
        bit_cnt_d = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (P_s) begin
          p_out_d   = sh_q[FRAME_W-1];
          p_valid_d = 1'b1;
          sh_d      = {sh_q[FRAME_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(FRAME_W - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cs_n_q    <= 1'b1;
      addr_q    <= '0;
      rvalid_q  <= 1'b0;
      sum_q     <= '0;
      max_q     <= '0;
      max_val_q <= '0;
      avg_val_q <= '0;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      p_out_q   <= 1'b0;
      p_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_n_q    <= cs_n_d;
      addr_q    <= addr_d;
      rvalid_q  <= rvalid_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
      max_val_q <= max_val_d;
      avg_val_q <= avg_val_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      p_out_q   <= p_out_d;
      p_valid_q <= p_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sram.cs_n   = cs_n_q;
  assign sram.we_n   = 1'b1;
  assign sram.addr   = addr_q;
  assign P_out       = p_out_q;
  assign p_valid     = p_valid_q;
  assign busy        = busy_q;
  assign avgmax_done = done_q;
  assign max_val     = max_val_q;
  assign avg_val     = avg_val_q;

endmodule

// File: tb/tb_avgmax_unit.sv
// Self-checking bench for avgmax_unit: SRAM model, frame capture and
// a reference model computing max/avg directly from the memory contents.
module tb_avgmax_unit;

  localparam int NW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        avgmax_en;
  logic        P_s;
  logic        P_out;
  logic        p_valid;
  logic        busy;
  logic        avgmax_done;
  logic [16:0] max_val;
  logic [16:0] avg_val;

  avgmax_unit_if #(.ADDR_W(8)) sif ();

  avgmax_unit #(
    .ADDR_W(8), .NUM_WORDS(NW), .LOG2_N(5), .DATA_W(17)
  ) dut (
    .clk(clk), .rst(rst), .avgmax_en(avgmax_en), .P_s(P_s),
    .sram(sif.master), .P_out(P_out), .p_valid(p_valid),
    .busy(busy), .avgmax_done(avgmax_done),
    .max_val(max_val), .avg_val(avg_val)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];

  always @(posedge clk)
    if (!sif.cs_n) sif.rdata <= mem[sif.addr];

  int n_chk = 0;
  int n_fail = 0;

  // observations of one run
  int          o_nbits, o_nreads, o_first_v, o_last_v;
  int          o_done_c, o_ndone, o_extra_done;
  bit          o_addr_ok, o_we_low, o_stall_bad, o_busy_after;
  logic [33:0] o_frame;

  function automatic logic [33:0] model();
    longint      s;
    logic [16:0] m;
    logic [16:0] w;
    s = 0;
    m = 0;
    for (int i = 0; i < NW; i++) begin
      w = mem[i][16:0];
      s += w;
      if (w > m) m = w;
    end
    return {m, 17'(s / NW)};
  endfunction

  task automatic run(input int ps_mode, input int spur_c);
    int   c;
    logic ps_prev;
    o_nbits = 0; o_nreads = 0; o_first_v = -1; o_last_v = -1;
    o_done_c = -1; o_ndone = 0; o_extra_done = 0;
    o_addr_ok = 1; o_we_low = 0; o_stall_bad = 0; o_busy_after = 1;
    o_frame = '0;
    @(negedge clk);
    avgmax_en = 1'b1;
    P_s = 1'b1;
    ps_prev = 1'b1;
    @(negedge clk);
    avgmax_en = 1'b0;
    c = 1;
    while (c < 600 && o_ndone == 0) begin
      if (!sif.cs_n) begin
        if (sif.addr !== 8'(o_nreads)) o_addr_ok = 0;
        o_nreads++;
      end
      if (sif.we_n !== 1'b1) o_we_low = 1;
      if (p_valid) begin
        if (!ps_prev) o_stall_bad = 1;
        if (o_nbits == 0) o_first_v = c;
        o_last_v = c;
        if (o_nbits < 34) o_frame[33 - o_nbits] = P_out;
        o_nbits++;
      end
      if (avgmax_done) begin
        o_ndone++;
        o_done_c = c;
        o_busy_after = busy;
      end
      case (ps_mode)
        0: P_s = 1'b1;
        1: P_s = (c % 4 == 1 || c % 4 == 2) ? 1'b0 : 1'b1;
        default: P_s = 1'($urandom);
      endcase
      ps_prev = P_s;
      avgmax_en = (c == spur_c);
      @(negedge clk);
      c++;
    end
    avgmax_en = 1'b0;
    P_s = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (avgmax_done) o_extra_done++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; avgmax_en = 1'b0; P_s = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({sif.cs_n, sif.we_n, sif.addr} !== 10'b11_0000_0000) begin
      n_fail++;
      $display("FAIL reset_sram got cs=%b we=%b addr=%0d want 1 1 0",
               sif.cs_n, sif.we_n, sif.addr);
    end
    n_chk++;
    if ({P_out, p_valid, busy, avgmax_done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b%b%b%b want 0000",
               P_out, p_valid, busy, avgmax_done);
    end
    n_chk++;
    if ({max_val, avg_val} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_vals got max=%0h avg=%0h want 0 0",
               max_val, avg_val);
    end
  endtask

  task automatic test_ramp();
    logic [33:0] e;
    for (int i = 0; i < 256; i++) mem[i] = {15'($urandom), 17'(i)};
    e = model();
    run(0, -1);
    n_chk++;
    if (!(o_addr_ok && o_nreads == NW)) begin
      n_fail++;
      $display("FAIL ramp_reads got n=%0d ok=%0b want n=32 ok=1",
               o_nreads, o_addr_ok);
    end
    n_chk++;
    if (max_val !== e[33:17]) begin
      n_fail++;
      $display("FAIL ramp_max got %0d want %0d", max_val, e[33:17]);
    end
    n_chk++;
    if (avg_val !== e[16:0]) begin
      n_fail++;
      $display("FAIL ramp_avg got %0d want %0d", avg_val, e[16:0]);
    end
    n_chk++;
    if (o_frame !== e || o_nbits != 34) begin
      n_fail++;
      $display("FAIL ramp_frame got %h/%0d want %h/34", o_frame, o_nbits, e);
    end
    n_chk++;
    if (o_first_v != NW + 4) begin
      n_fail++;
      $display("FAIL ramp_latency got %0d want %0d", o_first_v - 1, NW + 3);
    end
    n_chk++;
    if (o_done_c != o_last_v + 1 || o_last_v - o_first_v != 33) begin
      n_fail++;
      $display("FAIL ramp_done_timing got done=%0d first=%0d last=%0d",
               o_done_c, o_first_v, o_last_v);
    end
    n_chk++;
    if (o_we_low || o_extra_done != 0 || o_busy_after) begin
      n_fail++;
      $display("FAIL ramp_misc got we_low=%0b extra=%0d busy=%0b want 0 0 0",
               o_we_low, o_extra_done, o_busy_after);
    end
  endtask

  task automatic test_saturated();
    logic [33:0] e;
    for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_FFFF;
    e = model();
    run(0, -1);
    n_chk++;
    if (max_val !== e[33:17] || avg_val !== e[16:0]) begin
      n_fail++;
      $display("FAIL sat_vals got %h %h want %h %h",
               max_val, avg_val, e[33:17], e[16:0]);
    end
    n_chk++;
    if (o_frame !== e) begin
      n_fail++;
      $display("FAIL sat_frame got %h want %h", o_frame, e);
    end
  endtask

  task automatic test_max_last();
    logic [33:0] e;
    for (int i = 0; i < 256; i++) mem[i] = {15'($urandom), 17'd0};
    mem[NW-1] = 32'h0001_0000;
    e = model();
    run(0, -1);
    n_chk++;
    if (max_val !== e[33:17] || avg_val !== e[16:0]) begin
      n_fail++;
      $display("FAIL maxlast_vals got %h %h want %h %h",
               max_val, avg_val, e[33:17], e[16:0]);
    end
    n_chk++;
    if (o_frame !== e) begin
      n_fail++;
      $display("FAIL maxlast_frame got %h want %h", o_frame, e);
    end
  endtask

  task automatic test_stall();
    logic [33:0] e;
    for (int i = 0; i < 256; i++) mem[i] = {15'($urandom), 17'(i)};
    e = model();
    run(1, -1);
    n_chk++;
    if (o_frame !== e || o_nbits != 34) begin
      n_fail++;
      $display("FAIL stall_frame got %h/%0d want %h/34", o_frame, o_nbits, e);
    end
    n_chk++;
    if (o_stall_bad || o_ndone != 1) begin
      n_fail++;
      $display("FAIL stall_valid got bad=%0b done=%0d want 0 1",
               o_stall_bad, o_ndone);
    end
  endtask

  task automatic test_random();
    logic [33:0] e;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      if (r == 1) mem[7] = {15'd0, mem[3][16:0]};
      e = model();
      run(2, -1);
      n_chk++;
      if (o_frame !== e || o_nbits != 34 || o_stall_bad) begin
        n_fail++;
        $display("FAIL rand%0d_frame got %h/%0d bad=%0b want %h/34",
                 r, o_frame, o_nbits, o_stall_bad, e);
      end
      n_chk++;
      if (max_val !== e[33:17] || avg_val !== e[16:0]) begin
        n_fail++;
        $display("FAIL rand%0d_vals got %h %h want %h %h",
                 r, max_val, avg_val, e[33:17], e[16:0]);
      end
    end
  endtask

  task automatic test_abort_restart();
    logic [33:0] e;
    int          n;
    bit          hit;
    for (int i = 0; i < 256; i++) mem[i] = {15'($urandom), 17'(i)};
    @(negedge clk);
    avgmax_en = 1'b1;
    @(negedge clk);
    avgmax_en = 1'b0;
    hit = 0;
    for (int k = 0; k < 50 && !hit; k++) begin
      if (!sif.cs_n && sif.addr == 8'd10) hit = 1;
      else @(negedge clk);
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL abort_reach got no addr 10 want addr 10");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({sif.cs_n, sif.addr, P_out, p_valid, busy, avgmax_done} !==
        {1'b1, 8'd0, 4'b0} || {max_val, avg_val} !== 34'd0) begin
      n_fail++;
      $display("FAIL abort_state got cs=%b a=%0d o=%b v=%b b=%b d=%b m=%h a=%h",
               sif.cs_n, sif.addr, P_out, p_valid, busy, avgmax_done,
               max_val, avg_val);
    end
    n = 0;
    for (int k = 0; k < 80; k++) begin
      if (avgmax_done || busy) n++;
      @(negedge clk);
    end
    n_chk++;
    if (n != 0) begin
      n_fail++;
      $display("FAIL abort_quiet got %0d active cycles want 0", n);
    end
    e = model();
    run(0, 50);
    n_chk++;
    if (!(o_addr_ok && o_nreads == NW) || o_frame !== e || o_nbits != 34) begin
      n_fail++;
      $display("FAIL restart_run got n=%0d ok=%0b fr=%h/%0d want 32 1 %h/34",
               o_nreads, o_addr_ok, o_frame, o_nbits, e);
    end
    n_chk++;
    if (o_ndone != 1 || o_extra_done != 0) begin
      n_fail++;
      $display("FAIL spurious_en got done=%0d extra=%0d want 1 0",
               o_ndone, o_extra_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    avgmax_en = 1'b0;
    P_s = 1'b0;
    test_reset();
    test_ramp();
    test_saturated();
    test_max_last();
    test_stall();
    test_random();
    test_abort_restart();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/avgmax_unit.md
Name: avgmax_unit

Overview:
- Post-processing stage directly downstream of the result SRAM.
- Once the matrix results are written, it reads NUM_WORDS results back from SRAM.
- It tracks the unsigned maximum and the running sum, then computes the average.
- It serialises {max, avg} MSB-first onto P_out for the chip output pin.

Parameters:
- ADDR_W, 8, SRAM word address width.
- NUM_WORDS, 32, number of result words read per run; must equal 2**LOG2_N.
- LOG2_N, 5, shift amount for the average.
- DATA_W, 17, width of one result, taken from sram_rdata[DATA_W-1:0].

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- avgmax_en  in  1  start pulse; sampled only in IDLE.
- P_s  in  1  serial-advance enable; P_out shifts only while high.
- sram_cs_n  out  1  SRAM chip select, active low.
- sram_we_n  out  1  SRAM write enable, active low; held high (read only).
- sram_addr  out  ADDR_W  SRAM read address.
- sram_rdata  in  32  SRAM read data; valid the cycle after a cs_n-low read.
- P_out  out  1  serial result bit.
- p_valid  out  1  high while P_out carries a frame bit.
- busy  out  1  high in every state except IDLE.
- avgmax_done  out  1  one-cycle pulse at end of frame.
- max_val  out  DATA_W  registered maximum, stable from CALC until next start.
- avg_val  out  DATA_W  registered average, stable from CALC until next start.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - FSM goes to IDLE.
  - sram_cs_n=1, sram_we_n=1, sram_addr=0.
  - P_out=0, p_valid=0, busy=0, avgmax_done=0.
  - max_val=0, avg_val=0; internal sum, counters and shift register cleared.
  - Reset mid-operation aborts immediately with no done pulse.
- FSM states:
  - IDLE: wait for avgmax_en=1, then go to READ. Clear sum, max and the address counter in the same edge.
  - READ: sram_cs_n=0, sram_addr = counter 0..NUM_WORDS-1, one per cycle. After address NUM_WORDS-1 is issued, go to DRAIN.
  - DRAIN: sram_cs_n=1; capture the last returning word (one cycle), then go to CALC.
  - CALC: avg_val = sum >> LOG2_N (truncate), max_val = max register. Load shift reg = {max, avg} (2*DATA_W bits). Go to SHIFT.
  - SHIFT: while P_s=1, drive P_out = shift reg MSB and p_valid=1; shift left and increment the bit counter each cycle. While P_s=0, hold P_out and the counter with p_valid=0. After the 2*DATA_W-th bit is shifted, go to DONE.
  - DONE: avgmax_done=1 for one cycle, then go to IDLE.
- Read pipeline:
  - rvalid is a 1-cycle delayed copy of (state==READ).
  - On rvalid: sum += rdata[DATA_W-1:0], and max updates if the word is strictly greater.
  - rdata[31:DATA_W] is ignored.
- Arithmetic:
  - All operands unsigned.
  - sum width is DATA_W+LOG2_N (22 bits); it cannot overflow for NUM_WORDS words.
  - Ties in max keep the existing value. Max starts at 0.
- avgmax_en while busy=1 is ignored; there is no restart.
- P_s before SHIFT is ignored.
- Latency, with P_s tied high:
  - avgmax_en seen to first p_valid = NUM_WORDS+3 cycles.
  - Frame length is 2*DATA_W=34 cycles.
  - avgmax_done fires 1 cycle after the last bit.

Test Plan:
- Ramp: SRAM words 0..31 hold 0..31, P_s=1, pulse avgmax_en.
  - 32 reads at addr 0..31 then cs_n=1.
  - max_val=31, avg_val=15.
  - P_out frame = 17'd31 then 17'd15 MSB-first over 34 cycles.
  - avgmax_done pulse one cycle later.
- Saturated: all words 0x1FFFF with upper bits 0xFFFF junk.
  - sum=0x3FFFE0 with no overflow.
  - max_val=avg_val=0x1FFFF; upper rdata bits have no effect.
- Max at last address: words 0 except word 31=0x10000.
  - max_val=0x10000 (captured in DRAIN), avg_val=0x800.
- P_s stall: ramp data, P_s toggling 1-0-0-1 during SHIFT.
  - p_valid low while P_s=0, and the frame bits still match the Ramp case.
  - Total frame still 34 valid bits.
- Reset and spurious start:
  - Assert rst at READ address 10: all outputs at reset values next cycle, no avgmax_done.
  - Pulse avgmax_en during SHIFT: no effect on the frame.
  - A new avgmax_en after DONE runs cleanly from addr 0.
